// File: rtl/iob_pipe_reg_re.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse, synchronous flush,
// global enable, clock enable and a registered occupancy count.
module iob_pipe_reg_re #(
    parameter int                 DATA_W  = 21,
    parameter int                 DEPTH   = 2,
    parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}},
    parameter int                 LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               cke_i,
    input  logic               arst_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [DATA_W-1:0]  data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [DATA_W-1:0]  data_o,
    output logic [LEVEL_W-1:0] level_o
);

    logic [DEPTH-1:0]   r_v;
    logic [DATA_W-1:0]  r_d [DEPTH];
    logic [LEVEL_W-1:0] r_level;

    logic [DEPTH-1:0]   w_adv;
    logic [DEPTH-1:0]   w_free;
    logic [DEPTH-1:0]   w_load;
    logic               w_hold;
    logic               w_ready;
    logic               w_acc;
    logic               w_emit;

    // Advance/free chain runs from the output stage back to stage 0 so a draining
    // output can open a slot at the input in the same cycle.
    always_comb begin
        w_adv  = '0;
        w_free = '0;
        w_load = '0;
        w_hold = arst_i | (cke_i & (rst_i | ~en_i));
        w_adv[DEPTH-1]  = r_v[DEPTH-1] & ready_i;
        w_free[DEPTH-1] = ~r_v[DEPTH-1] | w_adv[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_adv[k]  = r_v[k] & w_free[k+1];
            w_free[k] = ~r_v[k] | w_adv[k];
        end
        w_ready   = w_free[0] & ~w_hold;
        w_acc     = valid_i & w_ready;
        w_emit    = w_adv[DEPTH-1];
        w_load[0] = w_acc;
        for (int k = 1; k < DEPTH; k++) begin
            w_load[k] = w_adv[k-1];
        end
    end

    // Stage valid bits, stage data and occupancy; data only moves on a load.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_v     <= '0;
            r_level <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= RST_VAL;
            end
        end else if (cke_i) begin
            if (rst_i) begin
                r_v     <= '0;
                r_level <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    r_d[k] <= RST_VAL;
                end
            end else if (en_i) begin
                for (int k = 0; k < DEPTH; k++) begin
                    r_v[k] <= w_load[k] | (r_v[k] & ~w_adv[k]);
                end
                if (w_load[0]) begin
                    r_d[0] <= data_i;
                end
                for (int k = 1; k < DEPTH; k++) begin
                    if (w_load[k]) begin
                        r_d[k] <= r_d[k-1];
                    end
                end
                r_level <= r_level + LEVEL_W'(w_acc) - LEVEL_W'(w_emit);
            end
        end
    end

    assign ready_o = w_ready;
    assign valid_o = r_v[DEPTH-1] & ~w_hold;
    assign data_o  = r_d[DEPTH-1];
    assign level_o = r_level;

endmodule
